morse_key_ctrl: RTL
===================

MORSE_KEY_CTRL -- requirements
Module: morse_key_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000: clk_fast cycles per timing tick; legal range 2..65535.
REQ-002 Parameter DASH_TICKS, default 20: a press of at least this many ticks is a dash.
REQ-003 Parameter LETTER_GAP, default 20: release ticks that end a letter; 1..255.
REQ-004 Parameter WORD_GAP, default 50: release ticks that end a word; LETTER_GAP < WORD_GAP <= 255.
REQ-005 clk_fast  in  1  single clock for the whole block.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 key_in  in  1  debounced key level; 1 = pressed.
REQ-008 code_valid  out  1  letter available.
REQ-009 code_ready  in  1  consumer accepts the letter.
REQ-010 code_bits  out  5  symbols; 0 = dot, 1 = dash.
REQ-011 code_len  out  3  symbol count, 1..5.
REQ-012 overflow  out  1  sticky flag: a sixth symbol arrived in one letter.
REQ-013 word_space  out  1  one-cycle pulse at end of word (macro-dependent).

Function
REQ-014 The prescaler shall count 0..TICK_DIV-1, pulse tick on the terminal count, and clear whenever dur is cleared.
REQ-015 dur shall be 8 bits, increment on tick, and saturate at 255.
REQ-016 States: IDLE, PRESS, GAP, EMIT, WORD; reset state IDLE.
REQ-017 IDLE: key_in=1 shall clear dur and enter PRESS next cycle.
REQ-018 PRESS: on key_in=0, classify the symbol (dur < DASH_TICKS gives 0, otherwise 1), then clear dur and enter GAP.
REQ-019 A classified symbol shall shift into code_bits bit 0, with earlier symbols moving left, and code_len shall increment; the first symbol ends at bit code_len-1; unused upper bits are 0.
REQ-020 If code_len=5 at classification, the symbol shall be discarded and overflow set; the letter is still emitted with 5 symbols.
REQ-021 GAP: key_in=1 shall clear dur and enter PRESS; dur reaching LETTER_GAP shall enter EMIT.
REQ-022 EMIT: code_valid=1; code_bits and code_len shall be held stable until code_valid=1 and code_ready=1 in the same cycle.
REQ-023 On handshake, symbol storage shall be cleared and code_valid shall drop the next cycle.
REQ-024 A rising key_in during EMIT shall set a pending flag; on handshake, if pending is set, the block shall clear dur and pending and enter PRESS, otherwise enter WORD (macro on) or IDLE (macro off).
REQ-025 dur shall keep counting through EMIT, so the word gap is measured from the last release.
REQ-026 WORD: key_in=1 shall clear dur and enter PRESS; dur reaching WORD_GAP shall pulse word_space for one cycle and enter IDLE.
REQ-027 Where key_in changes and dur hits a threshold on the same cycle, the key_in change shall take priority.
REQ-028 All outputs shall be registered.

Reset
REQ-029 When rst is asserted, state shall be IDLE and dur, prescaler, code_bits, code_len, pending, code_valid, overflow and word_space shall all be 0, immediately and without a clock.
REQ-030 Reset mid-letter or mid-EMIT shall discard the letter with no code_valid pulse.
REQ-031 overflow shall clear only on rst.

Configuration
REQ-032 Macro MORSE_WORD_SPACE_EN defined: WORD state and word_space pulses are present.
REQ-033 Without MORSE_WORD_SPACE_EN: WORD is removed, EMIT exits to IDLE, and word_space is tied to 0.

Verification (TICK_DIV=2, DASH_TICKS=3, LETTER_GAP=3, WORD_GAP=7, code_ready=1)
REQ-034 Press 2 ticks, release 1 tick, press 4 ticks, release 3 ticks -> one code_valid cycle with code_bits=00001, code_len=2 ("A").
REQ-035 Six 1-tick dots separated by 1-tick gaps -> overflow=1, code_bits=00000, code_len=5.
REQ-036 code_ready=0 for 10 cycles after a letter -> code_valid and code_bits are held stable; handshake on cycle 11 -> code_valid=0 on cycle 12.
REQ-037 With the macro on, a letter followed by 7 idle ticks -> word_space pulses once at dur=7; with the macro off -> word_space stays 0.
REQ-038 rst pulsed during PRESS with code_len=2 -> all outputs 0 and no code_valid; the next letter decodes correctly.

Source files
------------

// File: rtl/morse_key_ctrl.sv
// morse_key_ctrl: turns a debounced telegraph key level into Morse letters.
// Timing runs off a prescaled tick; each press is classified as a dot or a dash
// by how long it lasts, and a release gap ends the letter or the word.
//
// Ports:
//   clk_fast    in   single clock for the whole block
//   rst         in   asynchronous active-high reset
//   key_in      in   debounced key level, 1 = pressed
//   code_valid  out  letter available (held until code_ready)
//   code_ready  in   consumer accepts the letter
//   code_bits   out  [4:0] symbols, 0 = dot, 1 = dash, newest in bit 0
//   code_len    out  [2:0] symbol count, 1..5
//   overflow    out  sticky: a sixth symbol arrived in one letter
//   word_space  out  one-cycle pulse at end of word
//
// Build option: define MORSE_WORD_SPACE_EN to include the WORD state and the
// word_space pulse; without it EMIT returns to IDLE and word_space is 0.
module morse_key_ctrl #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DASH_TICKS = 20,
  parameter int unsigned LETTER_GAP = 20,
  parameter int unsigned WORD_GAP   = 50
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       key_in,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [4:0] code_bits,
  output logic [2:0] code_len,
  output logic       overflow,
  output logic       word_space
);

  localparam int unsigned PW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = 5;
  localparam int unsigned LW = 3;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DASH_TH    = DW'(DASH_TICKS);
  localparam logic [DW-1:0] LGAP_TH    = DW'(LETTER_GAP);
  localparam logic [DW-1:0] DUR_MAX    = '1;
  localparam logic [LW-1:0] LEN_MAX    = LW'(BW);

  // Reject parameter sets outside the supported ranges at elaboration.
  if ((TICK_DIV < 2) || (TICK_DIV > 65535) || (LETTER_GAP < 1) ||
      (WORD_GAP <= LETTER_GAP) || (WORD_GAP > 255)) begin : g_bad_cfg
    $error("morse_key_ctrl: illegal parameter set");
  end

`ifdef MORSE_WORD_SPACE_EN
  localparam logic [DW-1:0] WGAP_TH = DW'(WORD_GAP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRESS = 3'd1,
    S_GAP   = 3'd2,
    S_EMIT  = 3'd3,
    S_WORD  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRESS = 3'd1,
    S_GAP   = 3'd2,
    S_EMIT  = 3'd3
  } state_e;
`endif

  state_e state_q, state_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [BW-1:0] bits_q, bits_d;
  logic [LW-1:0] len_q, len_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          pend_q, pend_d;
  logic          key_q;
`ifdef MORSE_WORD_SPACE_EN
  logic          ws_q, ws_d;
`endif

  logic tick_c;
  logic key_rise_c;
  logic hs_c;
  logic sym_c;
  logic pend_now_c;
  logic clr_dur_c;

  assign tick_c     = (presc_q == PRESC_LAST);
  assign key_rise_c = key_in & ~key_q;
  assign hs_c       = valid_q & code_ready;
  assign sym_c      = (dur_q >= DASH_TH);
  // A press that starts in the handshake cycle itself counts as pending.
  assign pend_now_c = pend_q | key_rise_c;

  // State register.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; key activity wins over any gap threshold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (key_in) state_d = S_PRESS;
      end
      S_PRESS: begin
        if (!key_in) state_d = S_GAP;
      end
      S_GAP: begin
        if (key_in)                  state_d = S_PRESS;
        else if (dur_q >= LGAP_TH)   state_d = S_EMIT;
      end
      S_EMIT: begin
        if (hs_c) begin
`ifdef MORSE_WORD_SPACE_EN
          state_d = pend_now_c ? S_PRESS : S_WORD;
`else
          state_d = pend_now_c ? S_PRESS : S_IDLE;
`endif
        end
      end
`ifdef MORSE_WORD_SPACE_EN
      S_WORD: begin
        if (key_in)                  state_d = S_PRESS;
        else if (dur_q >= WGAP_TH)   state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    presc_d   = tick_c ? '0 : presc_q + PW'(1);
    dur_d     = (tick_c && (dur_q != DUR_MAX)) ? dur_q + DW'(1) : dur_q;
    bits_d    = bits_q;
    len_d     = len_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    pend_d    = pend_q;
    clr_dur_c = 1'b0;
`ifdef MORSE_WORD_SPACE_EN
    ws_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (key_in) clr_dur_c = 1'b1;
      end
      S_PRESS: begin
        if (!key_in) begin
          clr_dur_c = 1'b1;
          // A sixth symbol is dropped; the five already held still go out.
          if (len_q == LEN_MAX) begin
            ovf_d = 1'b1;
          end else begin
            bits_d = {bits_q[BW-2:0], sym_c};
            len_d  = len_q + LW'(1);
          end
        end
      end
      S_GAP: begin
        if (key_in)                  clr_dur_c = 1'b1;
        else if (dur_q >= LGAP_TH)   valid_d   = 1'b1;
      end
      S_EMIT: begin
        // dur keeps running here so the word gap counts from the last release.
        if (key_rise_c) pend_d = 1'b1;
        if (hs_c) begin
          valid_d = 1'b0;
          bits_d  = '0;
          len_d   = '0;
          pend_d  = 1'b0;
          if (pend_now_c) clr_dur_c = 1'b1;
        end
      end
`ifdef MORSE_WORD_SPACE_EN
      S_WORD: begin
        if (key_in)                  clr_dur_c = 1'b1;
        else if (dur_q >= WGAP_TH)   ws_d      = 1'b1;
      end
`endif
      default: ;
    endcase
    // The prescaler restarts with dur so every interval starts on a full tick.
    if (clr_dur_c) begin
      presc_d = '0;
      dur_d   = '0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      dur_q   <= '0;
      bits_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      key_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      dur_q   <= dur_d;
      bits_q  <= bits_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      key_q   <= key_in;
    end
  end

`ifdef MORSE_WORD_SPACE_EN
  // Word-space pulse register.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      ws_q <= 1'b0;
    end else begin
      ws_q <= ws_d;
    end
  end

  assign word_space = ws_q;
`else
  assign word_space = 1'b0;
`endif

  assign code_valid = valid_q;
  assign code_bits  = bits_q;
  assign code_len   = len_q;
  assign overflow   = ovf_q;

endmodule
